// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues sequential single-cycle memory reads and buffers
// {pc, instr} pairs in a circular queue for decode, with redirect and credit-based flow control.
module fetch_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ADDR_W   = 8,
  parameter int unsigned     QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [XLEN-1:0]   imem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_instr
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CRW   = CNT_W + 1;

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  req_pc;
  logic             inflight;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  q_pc    [QDEPTH];
  logic [XLEN-1:0]  q_instr [QDEPTH];

  logic             pop;
  logic             push;
  logic [CRW-1:0]   credit;
  logic             unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign imem_addr = fetch_pc[ADDR_W-1:0];
  assign out_valid = (count != '0);
  assign out_pc    = q_pc[rd_ptr];
  assign out_instr = q_instr[rd_ptr];

  assign pop  = out_valid && out_ready;
  // A redirect squashes the response arriving this cycle by suppressing its push.
  assign push = inflight && !redirect_valid;

  // Occupancy after this cycle's pop plus the response still owed from last cycle's request.
  always_comb begin
    credit = CRW'(count) - CRW'(pop) + CRW'(inflight);
  end

  assign imem_req = rst && !redirect_valid && (credit < CRW'(QDEPTH));

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        req_pc <= fetch_pc;
      end
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (imem_req) begin
          fetch_pc <= fetch_pc + XLEN'(4);
        end
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        unique case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      q_pc[wr_ptr]    <= req_pc;
      q_instr[wr_ptr] <= imem_data;
    end
  end

  no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    push |-> (count != CNT_W'(QDEPTH)));

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_fetch_stage;

  localparam int unsigned   QDEPTH   = 4;
  localparam logic [31:0]   RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  always #5 clk = ~clk;

  fetch_stage #(
    .XLEN(32), .ADDR_W(8), .QDEPTH(QDEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {24'h0, a};
  endfunction

  // Memory answers one cycle after a request; junk otherwise so stray pushes are visible.
  always @(posedge clk) imem_data <= imem_req ? mem_word(imem_addr) : $urandom();

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mq[$];
  logic [31:0] mpend[$];
  logic [31:0] mpc = RESET_PC;
  bit          model_on = 0;

  task automatic drive(input bit r, input bit rd, input logic [31:0] rp, input bit rdy);
    @(negedge clk);
    rst = r; redirect_valid = rd; redirect_pc = rp; out_ready = rdy;
    #1;
  endtask

  // Compare current outputs with the model, then advance the model across the coming edge.
  task automatic model_step();
    bit v, pop, req;
    int occ;
    v   = (mq.size() != 0);
    pop = v && out_ready;
    occ = mq.size() - int'(pop) + mpend.size();
    req = rst && !redirect_valid && (occ < QDEPTH);
    if (model_on) begin
      check("m_valid", 32'(out_valid), 32'(v));
      check("m_req", 32'(imem_req), 32'(req));
      if (req) check("m_addr", 32'(imem_addr), 32'(mpc[7:0]));
      if (v) begin
        check("m_pc", out_pc, mq[0].pc);
        check("m_instr", out_instr, mq[0].instr);
      end
    end
    if (!rst) begin
      mq.delete(); mpend.delete(); mpc = RESET_PC;
    end else if (redirect_valid) begin
      mq.delete(); mpend.delete(); mpc = redirect_pc & ~32'h3;
    end else begin
      if (pop) void'(mq.pop_front());
      if (mpend.size() != 0) begin
        mq.push_back('{pc: mpend[0], instr: mem_word(mpend[0][7:0])});
        mpend.delete();
      end
      if (req) begin
        mpend.push_back(mpc);
        mpc += 32'd4;
      end
    end
    if (mq.size() > QDEPTH) check("m_overflow", 32'(mq.size()), QDEPTH);
    model_on = 1;
  endtask

  task automatic expect_cyc(input string name, input bit r, input bit rd, input logic [31:0] rp,
                            input bit rdy, input bit e_req, input logic [7:0] e_addr,
                            input bit e_valid, input logic [31:0] e_pc);
    drive(r, rd, rp, rdy);
    check({name, "_req"}, 32'(imem_req), 32'(e_req));
    if (e_req) check({name, "_addr"}, 32'(imem_addr), 32'(e_addr));
    check({name, "_valid"}, 32'(out_valid), 32'(e_valid));
    if (e_valid) begin
      check({name, "_pc"}, out_pc, e_pc);
      check({name, "_instr"}, out_instr, mem_word(e_pc[7:0]));
    end
    model_step();
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0, 1'b0);
    model_step();
    expect_cyc("rst", 1'b0, 1'b0, '0, 1'b0, 1'b0, 8'h00, 1'b0, '0);
  endtask

  task automatic fill_three(input string name);
    expect_cyc(name, 1, 0, 0, 0, 1, 8'h00, 0, 0);
    expect_cyc(name, 1, 0, 0, 0, 1, 8'h04, 0, 0);
    expect_cyc(name, 1, 0, 0, 0, 1, 8'h08, 1, 32'h0);
    expect_cyc(name, 1, 0, 0, 0, 1, 8'h0C, 1, 32'h0);
  endtask

  typedef struct {
    bit          rst;
    bit          redir;
    logic [31:0] rpc;
    bit          rdy;
    bit          e_req;
    logic [7:0]  e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // Streaming from reset, then a reset, then backpressure for 10 cycles and release.
    vecs.push_back('{0, 0, 0, 1, 0, 8'h00, 0, 32'h0});
    vecs.push_back('{1, 0, 0, 1, 1, 8'h00, 0, 32'h0});
    vecs.push_back('{1, 0, 0, 1, 1, 8'h04, 0, 32'h0});
    vecs.push_back('{1, 0, 0, 1, 1, 8'h08, 1, 32'h0});
    vecs.push_back('{1, 0, 0, 1, 1, 8'h0C, 1, 32'h4});
    vecs.push_back('{1, 0, 0, 1, 1, 8'h10, 1, 32'h8});
    vecs.push_back('{1, 0, 0, 1, 1, 8'h14, 1, 32'hC});
    vecs.push_back('{0, 0, 0, 1, 0, 8'h00, 1, 32'h10});
    vecs.push_back('{1, 0, 0, 0, 1, 8'h00, 0, 32'h0});
    vecs.push_back('{1, 0, 0, 0, 1, 8'h04, 0, 32'h0});
    vecs.push_back('{1, 0, 0, 0, 1, 8'h08, 1, 32'h0});
    vecs.push_back('{1, 0, 0, 0, 1, 8'h0C, 1, 32'h0});
    for (int i = 0; i < 6; i++) vecs.push_back('{1, 0, 0, 0, 0, 8'h00, 1, 32'h0});
    vecs.push_back('{1, 0, 0, 1, 1, 8'h10, 1, 32'h0});
    vecs.push_back('{1, 0, 0, 1, 1, 8'h14, 1, 32'h4});
    vecs.push_back('{1, 0, 0, 1, 1, 8'h18, 1, 32'h8});
    vecs.push_back('{1, 0, 0, 1, 1, 8'h1C, 1, 32'hC});
    vecs.push_back('{1, 0, 0, 1, 1, 8'h20, 1, 32'h10});
    vecs.push_back('{1, 0, 0, 1, 1, 8'h24, 1, 32'h14});

    drive(1'b0, 1'b0, '0, 1'b0);
    model_step();
    foreach (vecs[i])
      expect_cyc("vec", vecs[i].rst, vecs[i].redir, vecs[i].rpc, vecs[i].rdy,
                 vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_pc);

    // Redirect while the queue holds 3 and a 4th response is in flight.
    do_reset();
    fill_three("fullredir");
    expect_cyc("fullredir", 1, 1, 32'h43, 0, 0, 8'h00, 1, 32'h0);
    expect_cyc("fullredir", 1, 0, 0, 1, 1, 8'h40, 0, 0);
    expect_cyc("fullredir", 1, 0, 0, 1, 1, 8'h44, 0, 0);
    expect_cyc("fullredir", 1, 0, 0, 1, 1, 8'h48, 1, 32'h40);
    expect_cyc("fullredir", 1, 0, 0, 1, 1, 8'h4C, 1, 32'h44);

    // Pop of 0x8 in the same cycle as a redirect to 0x80.
    do_reset();
    expect_cyc("popredir", 1, 0, 0, 1, 1, 8'h00, 0, 0);
    expect_cyc("popredir", 1, 0, 0, 1, 1, 8'h04, 0, 0);
    expect_cyc("popredir", 1, 0, 0, 1, 1, 8'h08, 1, 32'h0);
    expect_cyc("popredir", 1, 0, 0, 1, 1, 8'h0C, 1, 32'h4);
    expect_cyc("popredir", 1, 1, 32'h80, 1, 0, 8'h00, 1, 32'h8);
    expect_cyc("popredir", 1, 0, 0, 1, 1, 8'h80, 0, 0);
    expect_cyc("popredir", 1, 0, 0, 1, 1, 8'h84, 0, 0);
    expect_cyc("popredir", 1, 0, 0, 1, 1, 8'h88, 1, 32'h80);

    // PC wrap at the top of the address space.
    do_reset();
    expect_cyc("wrap", 1, 1, 32'hFFFFFFF8, 1, 0, 8'h00, 0, 0);
    expect_cyc("wrap", 1, 0, 0, 1, 1, 8'hF8, 0, 0);
    expect_cyc("wrap", 1, 0, 0, 1, 1, 8'hFC, 0, 0);
    expect_cyc("wrap", 1, 0, 0, 1, 1, 8'h00, 1, 32'hFFFFFFF8);
    expect_cyc("wrap", 1, 0, 0, 1, 1, 8'h04, 1, 32'hFFFFFFFC);
    expect_cyc("wrap", 1, 0, 0, 1, 1, 8'h08, 1, 32'h00000000);

    // Back-to-back redirects: the second one wins.
    do_reset();
    expect_cyc("b2b", 1, 1, 32'h100, 1, 0, 8'h00, 0, 0);
    expect_cyc("b2b", 1, 1, 32'h202, 1, 0, 8'h00, 0, 0);
    expect_cyc("b2b", 1, 0, 0, 1, 1, 8'h00, 0, 0);
    expect_cyc("b2b", 1, 0, 0, 1, 1, 8'h04, 0, 0);
    expect_cyc("b2b", 1, 0, 0, 1, 1, 8'h08, 1, 32'h200);

    // One-cycle reset with 3 entries queued and one in flight.
    do_reset();
    fill_three("midrst");
    expect_cyc("midrst", 0, 0, 0, 0, 0, 8'h00, 1, 32'h0);
    expect_cyc("midrst", 1, 0, 0, 1, 1, 8'h00, 0, 0);
    expect_cyc("midrst", 1, 0, 0, 1, 1, 8'h04, 0, 0);
    expect_cyc("midrst", 1, 0, 0, 1, 1, 8'h08, 1, 32'h0);
    expect_cyc("midrst", 1, 0, 0, 1, 1, 8'h0C, 1, 32'h4);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      bit          r, rd, rdy;
      logic [31:0] rp;
      r   = ($urandom_range(63) != 0);
      rd  = ($urandom_range(11) == 0);
      rp  = $urandom();
      if ($urandom_range(3) == 0) rp = 32'hFFFFFFE0 | (rp & 32'h1F);
      rdy = ($urandom_range(9) < 7);
      drive(r, rd, rp, rdy);
      model_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
